window_buffer_kxk: RTL and testbench

- Parametrised successor to the fixed 3x3 Sobel window buffer: holds a WIN x WIN pixel window, DATA_W bits per pixel.
- Supports full load, shift left/right/down with refill of the vacated column/row, and clear, all under valid/ready handshakes.
- Sits between the pixel fetch/address controller (command and pixel source) and the convolution/gradient stage (window consumer).
- Owns its own fill counter.

---
 rtl/window_buffer_kxk.sv | 168 ++++++++++++++++
 tb/tb_window_buffer_kxk.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_buffer_kxk.sv
// WIN x WIN pixel window buffer: full load, left/right/down shift with refill of
// the vacated column/row, and clear, driven by command and pixel handshakes.
module window_buffer_kxk #(
    parameter int DATA_W = 8,
    parameter int WIN    = 3,
    parameter int CNT_W  = $clog2(WIN*WIN+1)
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic [DATA_W-1:0]          pix_data,
    output logic [WIN*WIN*DATA_W-1:0]  window_out,
    output logic                       window_valid,
    output logic                       done,
    output logic                       err,
    output logic [CNT_W-1:0]           pix_count
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_LEFT  = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_DOWN  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wvalid_q, wvalid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] win_q [WIN][WIN];
    logic [DATA_W-1:0] win_d [WIN][WIN];
    logic [CNT_W-1:0]  need;
    logic              last_pix;

    function automatic logic [CNT_W-1:0] need_of(input logic [2:0] op);
        case (op)
            OP_LOAD:                    return CNT_W'(WIN*WIN);
            OP_LEFT, OP_RIGHT, OP_DOWN: return CNT_W'(WIN);
            default:                    return '0;
        endcase
    endfunction

    // Fill order: load goes bottom row upward, columns bottom to top, row 0 left to right.
    function automatic logic slot_hit(input logic [2:0] op, input int r, input int c, input int k);
        case (op)
            OP_LOAD:  return k == (WIN-1-r)*WIN + c;
            OP_LEFT:  return (c == WIN-1) && (k == WIN-1-r);
            OP_RIGHT: return (c == 0) && (k == WIN-1-r);
            OP_DOWN:  return (r == 0) && (k == c);
            default:  return 1'b0;
        endcase
    endfunction

    assign need     = need_of(op_q);
    assign last_pix = (cnt_q == need - CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        wvalid_d = wvalid_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        win_d    = win_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    cnt_d    = '0;
                    wvalid_d = 1'b0;
                    state_d  = S_FILL;
                    case (cmd_op)
                        OP_LOAD, OP_CLEAR: begin
                            for (int r = 0; r < WIN; r++)
                                for (int c = 0; c < WIN; c++)
                                    win_d[r][c] = '0;
                        end
                        OP_LEFT: begin
                            for (int r = 0; r < WIN; r++) begin
                                for (int c = 0; c < WIN-1; c++)
                                    win_d[r][c] = win_q[r][c+1];
                                win_d[r][WIN-1] = '0;
                            end
                        end
                        OP_RIGHT: begin
                            for (int r = 0; r < WIN; r++) begin
                                for (int c = 1; c < WIN; c++)
                                    win_d[r][c] = win_q[r][c-1];
                                win_d[r][0] = '0;
                            end
                        end
                        OP_DOWN: begin
                            for (int c = 0; c < WIN; c++) begin
                                for (int r = 1; r < WIN; r++)
                                    win_d[r][c] = win_q[r-1][c];
                                win_d[0][c] = '0;
                            end
                        end
                        default: ;
                    endcase
                    // Clear and illegal ops need no pixels and complete immediately.
                    if (need_of(cmd_op) == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = (cmd_op > OP_CLEAR);
                    end
                end
            end
            S_FILL: begin
                if (pix_valid) begin
                    for (int r = 0; r < WIN; r++)
                        for (int c = 0; c < WIN; c++)
                            if (slot_hit(op_q, r, c, int'(cnt_q)))
                                win_d[r][c] = pix_data;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_pix) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        wvalid_d = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_LOAD;
            cnt_q    <= '0;
            wvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            win_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            wvalid_q <= wvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
            win_q    <= win_d;
        end
    end

    for (genvar gr = 0; gr < WIN; gr++) begin : g_row
        for (genvar gc = 0; gc < WIN; gc++) begin : g_col
            assign window_out[(gr*WIN+gc)*DATA_W +: DATA_W] = win_q[gr][gc];
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign pix_ready    = (state_q == S_FILL);
    assign window_valid = wvalid_q;
    assign done         = done_q;
    assign err          = err_q;
    assign pix_count    = cnt_q;

endmodule

// File: tb/tb_window_buffer_kxk.sv
// Scoreboard bench for window_buffer_kxk: a 3x3/8-bit instance exercises every op,
// a 5x5/10-bit instance repeats the full load.
module tb_window_buffer_kxk;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    logic        cmd_valid3, cmd_ready3, pix_valid3, pix_ready3, wv3, done3, err3;
    logic [2:0]  cmd_op3;
    logic [7:0]  pix_data3;
    logic [71:0] win3;
    logic [3:0]  cnt3;

    logic         cmd_valid5, cmd_ready5, pix_valid5, pix_ready5, wv5, done5, err5;
    logic [2:0]   cmd_op5;
    logic [9:0]   pix_data5;
    logic [249:0] win5;
    logic [4:0]   cnt5;

    window_buffer_kxk #(.DATA_W(8), .WIN(3)) dut3 (
        .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_op(cmd_op3), .pix_valid(pix_valid3), .pix_ready(pix_ready3),
        .pix_data(pix_data3), .window_out(win3), .window_valid(wv3),
        .done(done3), .err(err3), .pix_count(cnt3));

    window_buffer_kxk #(.DATA_W(10), .WIN(5)) dut5 (
        .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid5), .cmd_ready(cmd_ready5),
        .cmd_op(cmd_op5), .pix_valid(pix_valid5), .pix_ready(pix_ready5),
        .pix_data(pix_data5), .window_out(win5), .window_valid(wv5),
        .done(done5), .err(err5), .pix_count(cnt5));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [255:0] win;
        logic         err;
        logic         wv;
        int           cnt;
    } exp_t;
    exp_t exp_q[$];
    exp_t exp5_q[$];

    // Reference window, indexed [row][col], row 0 on top.
    int m[5][5];

    function automatic void m_zero();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                m[r][c] = 0;
    endfunction

    function automatic void m_shift(input int op, input int w);
        for (int r = 0; r < w; r++) begin
            if (op == 1) begin
                for (int c = 0; c < w-1; c++) m[r][c] = m[r][c+1];
                m[r][w-1] = 0;
            end else if (op == 2) begin
                for (int c = w-1; c > 0; c--) m[r][c] = m[r][c-1];
                m[r][0] = 0;
            end
        end
        if (op == 3) begin
            for (int r = w-1; r > 0; r--)
                for (int c = 0; c < w; c++) m[r][c] = m[r-1][c];
            for (int c = 0; c < w; c++) m[0][c] = 0;
        end
    endfunction

    function automatic void m_put(input int op, input int w, input int k, input int v);
        case (op)
            0: m[w-1-k/w][k%w] = v;
            1: m[w-1-k][w-1]   = v;
            2: m[w-1-k][0]     = v;
            3: m[0][k]         = v;
            default: ;
        endcase
    endfunction

    function automatic logic [255:0] m_pack(input int w, input int dw);
        logic [255:0] res = '0;
        for (int r = 0; r < w; r++)
            for (int c = 0; c < w; c++)
                res |= (256'(m[r][c] & ((1 << dw) - 1))) << ((r*w + c)*dw);
        return res;
    endfunction

    function automatic int need_of(input int op, input int w);
        if (op == 0) return w*w;
        if (op >= 1 && op <= 3) return w;
        return 0;
    endfunction

    function automatic int pix_val(input int base, input bit aa, input int i);
        return aa ? (8'hAA + 8'h11*i) : (base + i);
    endfunction

    // Issue one command to the 3x3 instance and stream its refill pixels.
    task automatic cmd3(input logic [2:0] op, input int base, input bit aa, input bit gap);
        int n;
        int need;
        logic [255:0] shifted;
        logic [255:0] fin;
        need = need_of(int'(op), 3);
        if (op == 3'd0 || op == 3'd4) m_zero();
        else if (op < 3'd4) m_shift(int'(op), 3);
        shifted = m_pack(3, 8);
        for (int i = 0; i < need; i++) m_put(int'(op), 3, i, pix_val(base, aa, i));
        fin = m_pack(3, 8);
        exp_q.push_back('{fin, (op > 3'd4), (op < 3'd4), need});
        n = 0;
        while (!cmd_ready3 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_ready", cmd_ready3, 1);
        cmd_valid3 = 1'b1;
        cmd_op3    = op;
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        chk("accept_win", win3, shifted);
        chk("accept_wv", wv3, 0);
        chk("accept_pix_ready", pix_ready3, need > 0);
        for (int i = 0; i < need; i++) begin
            pix_valid3 = 1'b1;
            pix_data3  = 8'(pix_val(base, aa, i));
            @(posedge clk); #1;
            pix_valid3 = 1'b0;
            chk("fill_cnt", cnt3, i + 1);
            if (gap && i < need - 1) begin
                pix_data3 = 8'hEE;
                @(posedge clk); #1;
                chk("gap_cnt", cnt3, i + 1);
                chk("gap_pix_ready", pix_ready3, 1);
            end
        end
        chk("done_pix_ready", pix_ready3, 0);
        chk("done_wv", wv3, op < 3'd4);
        @(posedge clk); #1;
        chk("done_one_cycle", done3, 0);
        chk("idle_cmd_ready", cmd_ready3, 1);
    endtask

    // Scoreboard: compare against the queued expectation whenever done pulses.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (err3 && !done3) chk("err3_without_done", 1, 0);
            if (done3) begin
                if (exp_q.size() == 0) chk("sb3_unexpected_done", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("sb3_win", win3, e.win);
                    chk("sb3_err", err3, e.err);
                    chk("sb3_wv", wv3, e.wv);
                    chk("sb3_cnt", cnt3, e.cnt);
                end
            end
            if (done5) begin
                if (exp5_q.size() == 0) chk("sb5_unexpected_done", 1, 0);
                else begin
                    e = exp5_q.pop_front();
                    chk("sb5_win", win5, e.win);
                    chk("sb5_err", err5, e.err);
                    chk("sb5_wv", wv5, e.wv);
                    chk("sb5_cnt", cnt5, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        n_rst = 1'b0;
        cmd_valid3 = 1'b0; cmd_op3 = 3'd0; pix_valid3 = 1'b0; pix_data3 = '0;
        cmd_valid5 = 1'b0; cmd_op5 = 3'd0; pix_valid5 = 1'b0; pix_data5 = '0;
        #12;
        chk("rst_win", win3, 0);
        chk("rst_cmd_ready", cmd_ready3, 1);
        chk("rst_pix_ready", pix_ready3, 0);
        chk("rst_wv", wv3, 0);
        chk("rst_done", done3, 0);
        chk("rst_err", err3, 0);
        chk("rst_cnt", cnt3, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        m_zero();

        cmd3(3'd0, 1, 1'b0, 1'b0);
        chk("load_row0", win3[23:0], 24'h090807);
        chk("load_row2", win3[71:48], 24'h030201);

        // A pixel offered in IDLE must be ignored.
        pix_valid3 = 1'b1;
        pix_data3  = 8'hFF;
        @(posedge clk); #1;
        pix_valid3 = 1'b0;
        chk("idle_pix_ignored", win3, m_pack(3, 8));
        chk("idle_cnt_hold", cnt3, 9);
        chk("idle_wv_hold", wv3, 1);

        cmd3(3'd1, 10, 1'b0, 1'b0);
        chk("left_row0", win3[23:0], 24'h0C0908);
        chk("left_row2", win3[71:48], 24'h0A0302);

        cmd3(3'd3, 0, 1'b1, 1'b1);
        cmd3(3'd2, 0, 1'b1, 1'b1);

        // Clear with a pixel offered alongside the command.
        pix_valid3 = 1'b1;
        pix_data3  = 8'h77;
        cmd3(3'd4, 0, 1'b0, 1'b0);
        pix_valid3 = 1'b0;
        chk("clear_win", win3, 0);

        cmd3(3'd0, 40, 1'b0, 1'b0);
        cmd3(3'd6, 0, 1'b0, 1'b0);
        chk("illegal_keeps_win", win3, m_pack(3, 8));

        // Reset partway through a load; a command offered mid-fill is refused.
        n = 0;
        while (!cmd_ready3 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        cmd_valid3 = 1'b1;
        cmd_op3    = 3'd0;
        @(posedge clk); #1;
        cmd_op3 = 3'd4;
        for (int i = 0; i < 4; i++) begin
            pix_valid3 = 1'b1;
            pix_data3  = 8'(i + 1);
            @(posedge clk); #1;
            chk("fill_cmd_ready", cmd_ready3, 0);
            chk("partial_cnt", cnt3, i + 1);
        end
        cmd_valid3 = 1'b0;
        pix_valid3 = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("midrst_win", win3, 0);
        chk("midrst_cmd_ready", cmd_ready3, 1);
        chk("midrst_pix_ready", pix_ready3, 0);
        chk("midrst_wv", wv3, 0);
        chk("midrst_done", done3, 0);
        chk("midrst_cnt", cnt3, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        m_zero();
        cmd3(3'd0, 100, 1'b0, 1'b0);

        // 5x5, 10-bit full load.
        m_zero();
        for (int k = 0; k < 25; k++) m_put(0, 5, k, k + 1);
        exp5_q.push_back('{m_pack(5, 10), 1'b0, 1'b1, 25});
        chk("w5_cmd_ready", cmd_ready5, 1);
        cmd_valid5 = 1'b1;
        cmd_op5    = 3'd0;
        @(posedge clk); #1;
        cmd_valid5 = 1'b0;
        chk("w5_pix_ready", pix_ready5, 1);
        for (int i = 0; i < 25; i++) begin
            pix_valid5 = 1'b1;
            pix_data5  = 10'(i + 1);
            @(posedge clk); #1;
            pix_valid5 = 1'b0;
            chk("w5_cnt", cnt5, i + 1);
        end
        chk("w5_done", done5, 1);
        for (int c = 0; c < 5; c++) chk("w5_top_row", win5[c*10 +: 10], 21 + c);
        @(posedge clk); #1;
        chk("w5_done_one_cycle", done5, 0);
        chk("w5_wv_hold", wv5, 1);

        chk("sb3_drain", exp_q.size(), 0);
        chk("sb5_drain", exp5_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
